// File: rtl/pool_stream.sv
// pool_stream: streaming multi-channel pooling unit.
//
// Every POOL_SIZE accepted input beats are reduced, lane by lane, into one
// result (signed max, or floor average when built with average support) that
// is held in a registered, back-pressurable output stage.
//
// Build option:
//   POOL_STREAM_AVG_EN  defined   -> max and average modes, sum registers and
//                                    shifter built; win_mode reports the mode.
//                       undefined -> max only; mode_avg ignored, win_mode = 0.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   clear             synchronous abort of partial window and pending result
//   mode_avg          1 = average, 0 = max; sampled on a window's first beat
//   in_valid/in_ready input handshake, in_data = CHANNELS signed lanes
//   out_valid/out_ready output handshake, out_data = registered results
//   win_mode          mode that produced the result on out_data
//   dbg_state         {output FULL, window ACCUM} for observation
//
// Handshake: a beat (or result) transfers on a rising edge where valid and
// ready are both high. in_ready depends combinationally on out_ready only;
// out_valid and out_data are registered.
module pool_stream #(
  parameter int DATA_W    = 8,
  parameter int CHANNELS  = 4,
  parameter int POOL_SIZE = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         mode_avg,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         win_mode,
  output logic [1:0]                   dbg_state
);

  localparam int CNT_W = $clog2(POOL_SIZE);
`ifdef POOL_STREAM_AVG_EN
  // Wide enough that POOL_SIZE summed elements never overflow.
  localparam int ACC_W = DATA_W + CNT_W;
`else
  localparam int ACC_W = DATA_W;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_SIZE - 1);

  typedef enum logic { WIN_IDLE, WIN_ACCUM } win_state_e;
  typedef enum logic { OUT_EMPTY, OUT_FULL } out_state_e;

  win_state_e                  win_state_q, win_state_d;
  out_state_e                  out_state_q, out_state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [ACC_W-1:0]     acc_q [CHANNELS];
  logic signed [ACC_W-1:0]     acc_d [CHANNELS];
  logic                        mode_q, mode_d;
  logic [CHANNELS*DATA_W-1:0]  out_data_q, out_data_d;
  logic                        win_mode_q, win_mode_d;

  logic signed [DATA_W-1:0]    lane_s [CHANNELS];
  logic signed [ACC_W-1:0]     ext    [CHANNELS];
  logic signed [ACC_W-1:0]     nxt    [CHANNELS];
  logic [DATA_W-1:0]           res    [CHANNELS];

  logic accept, first_beat, last_beat, beat_avg;

  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == CNT_LAST);
  // Only the window-closing beat can be stalled, and only by a held result
  // that is not leaving this cycle.
  assign in_ready   = !(last_beat && (out_state_q == OUT_FULL) && !out_ready);
  assign accept     = in_valid && in_ready;

`ifdef POOL_STREAM_AVG_EN
  assign beat_avg = first_beat ? mode_avg : mode_q;
`else
  logic unused_mode;
  assign beat_avg    = 1'b0;
  assign unused_mode = mode_avg ^ mode_q;
`endif

  always_comb begin
    cnt_d       = cnt_q;
    win_state_d = win_state_q;
    out_state_d = out_state_q;
    mode_d      = mode_q;
    out_data_d  = out_data_q;
    win_mode_d  = win_mode_q;
    for (int c = 0; c < CHANNELS; c++) begin
      acc_d[c]  = acc_q[c];
      lane_s[c] = in_data[c*DATA_W +: DATA_W];
      ext[c]    = ACC_W'(lane_s[c]);
      if (first_beat) begin
        nxt[c] = ext[c];
`ifdef POOL_STREAM_AVG_EN
      end else if (beat_avg) begin
        nxt[c] = acc_q[c] + ext[c];
`endif
      end else begin
        nxt[c] = (ext[c] > acc_q[c]) ? ext[c] : acc_q[c];
      end
`ifdef POOL_STREAM_AVG_EN
      // Arithmetic shift floors toward -inf; the quotient always fits DATA_W.
      res[c] = beat_avg ? DATA_W'(nxt[c] >>> CNT_W) : nxt[c][DATA_W-1:0];
`else
      res[c] = nxt[c];
`endif
    end

    if (clear) begin
      cnt_d       = '0;
      win_state_d = WIN_IDLE;
      out_state_d = OUT_EMPTY;
    end else begin
      if ((out_state_q == OUT_FULL) && out_ready) out_state_d = OUT_EMPTY;
      if (accept) begin
        mode_d = beat_avg;
        for (int c = 0; c < CHANNELS; c++) acc_d[c] = nxt[c];
        if (last_beat) begin
          cnt_d       = '0;
          win_state_d = WIN_IDLE;
          out_state_d = OUT_FULL;   // overrides a same-cycle retire
          win_mode_d  = beat_avg;
          for (int c = 0; c < CHANNELS; c++) out_data_d[c*DATA_W +: DATA_W] = res[c];
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          win_state_d = WIN_ACCUM;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_state_q <= WIN_IDLE;
      out_state_q <= OUT_EMPTY;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_data_q  <= '0;
      win_mode_q  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
    end else begin
      win_state_q <= win_state_d;
      out_state_q <= out_state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      win_mode_q  <= win_mode_d;
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= acc_d[c];
    end
  end

  assign out_valid = (out_state_q == OUT_FULL);
  assign out_data  = out_data_q;
  assign win_mode  = win_mode_q;
  assign dbg_state = {out_state_q == OUT_FULL, win_state_q == WIN_ACCUM};

endmodule

// File: tb/tb_pool_stream.sv
// Testbench for pool_stream: directed scenarios followed by random traffic,
// all checked against a window-level reference model and a result queue.
module tb_pool_stream;

  localparam int DW = 8;
  localparam int CH = 4;
  localparam int PS = 4;
  localparam int DWID = CH*DW;
  localparam int W = DWID + 1;   // {mode, data}
`ifdef POOL_STREAM_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            clear, mode_avg, in_valid, in_ready;
  logic [DWID-1:0] in_data, out_data;
  logic            out_valid, out_ready, win_mode;
  logic [1:0]      dbg_state;

  pool_stream #(.DATA_W(DW), .CHANNELS(CH), .POOL_SIZE(PS)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode_avg(mode_avg),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .win_mode(win_mode), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DWID-1:0] win_q[$];     // beats of the window being collected
  bit              win_mode_m;
  logic [W-1:0]    exp_q[$];     // results waiting to be consumed
  logic [W-1:0]    last_res;     // what out_data/win_mode must show
  logic            obs_rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [W-1:0] window_result(input bit avg);
    logic [DWID-1:0] res;
    logic [DWID-1:0] word;
    logic [DW-1:0]   b;
    int v, best, sum, m, r;
    res = '0;
    for (int c = 0; c < CH; c++) begin
      best = -100000;
      sum  = 0;
      for (int i = 0; i < PS; i++) begin
        word = win_q[i];
        b    = word[c*DW +: DW];
        v    = $signed(b);
        if (v > best) best = v;
        sum += v;
      end
      m = sum % PS;
      if (m < 0) m += PS;
      r = avg ? (sum - m) / PS : best;
      res[c*DW +: DW] = r[DW-1:0];
    end
    return {avg, res};
  endfunction

  function automatic logic [DWID-1:0] l0(input logic [DW-1:0] v);
    logic [DWID-1:0] r;
    r = DWID'($urandom);
    r[DW-1:0] = v;
    return r;
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input bit v, input logic [DWID-1:0] d, input bit ordy,
                       input bit clr, input bit mavg);
    bit exp_rdy, take, fire;
    in_valid = v; in_data = d; out_ready = ordy; clear = clr; mode_avg = mavg;
    @(negedge clk);
    exp_rdy = !(win_q.size() == PS-1 && exp_q.size() != 0 && !ordy);
    obs_rdy = in_ready;
    check("in_ready", in_ready, exp_rdy);
    take = v && exp_rdy;
    fire = (exp_q.size() != 0) && ordy;
    if (fire && !clr) check("retire", {win_mode, out_data}, exp_q[0]);
    @(posedge clk);
    if (clr) begin
      win_q.delete();
      exp_q.delete();
    end else begin
      if (fire) void'(exp_q.pop_front());
      if (take) begin
        if (win_q.size() == 0) win_mode_m = AVG ? mavg : 1'b0;
        win_q.push_back(d);
        if (win_q.size() == PS) begin
          last_res = window_result(win_mode_m);
          exp_q.push_back(last_res);
          win_q.delete();
        end
      end
    end
    #1;
    check("out_valid", out_valid, exp_q.size() != 0);
    check("out_data", out_data, last_res[DWID-1:0]);
    check("win_mode", win_mode, last_res[W-1]);
  endtask

  task automatic reset_mid;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_mode", win_mode, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    win_q.delete();
    exp_q.delete();
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; clear = 1'b0; mode_avg = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0; last_res = '0; win_mode_m = 1'b0;
    #3;
    check("reset_valid", out_valid, 1'b0);
    check("reset_data", out_data, '0);
    check("reset_mode", win_mode, 1'b0);
    check("reset_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Max window, lane0 3,-7,12,5
    cycle(1, l0(8'd3), 1, 0, 0);
    cycle(1, l0(-8'sd7), 1, 0, 0);
    cycle(1, l0(8'd12), 1, 0, 0);
    check("max_pre_valid", out_valid, 1'b0);
    cycle(1, l0(8'd5), 1, 0, 0);
    check("max_valid", out_valid, 1'b1);
    check("max_lane0", out_data[7:0], 8'd12);

    // All-negative lane
    cycle(1, l0(-8'sd128), 1, 0, 0);
    cycle(1, l0(-8'sd1), 1, 0, 0);
    cycle(1, l0(-8'sd50), 1, 0, 0);
    cycle(1, l0(-8'sd2), 1, 0, 0);
    check("neg_lane0", out_data[7:0], 8'hFF);

    // Average request: -3,-4,-4,-4
    cycle(1, l0(-8'sd3), 1, 0, 1);
    cycle(1, l0(-8'sd4), 1, 0, 1);
    cycle(1, l0(-8'sd4), 1, 0, 1);
    cycle(1, l0(-8'sd4), 1, 0, 1);
    check("avg_lane0", out_data[7:0], AVG ? 8'hFC : 8'hFD);
    check("avg_mode", win_mode, AVG);

    // Back-pressure: result held, second window streams
    cycle(1, l0(8'd1), 0, 0, 0);
    cycle(1, l0(8'd9), 0, 0, 0);
    cycle(1, l0(8'd2), 0, 0, 0);
    cycle(1, l0(8'd4), 0, 0, 0);
    check("bp_stall", obs_rdy, 1'b0);
    cycle(1, l0(8'd4), 1, 0, 0);
    check("bp_accept", obs_rdy, 1'b1);
    check("bp_lane0", out_data[7:0], 8'd9);

    // Mode toggled mid-window, then new mode for next window
    cycle(1, l0(8'd8), 1, 0, 0);
    cycle(1, l0(8'd4), 1, 0, 1);
    cycle(1, l0(8'd2), 1, 0, 1);
    cycle(1, l0(8'd2), 1, 0, 1);
    check("tog_lane0", out_data[7:0], 8'd8);
    check("tog_mode", win_mode, 1'b0);
    cycle(1, l0(8'd8), 1, 0, 1);
    cycle(1, l0(8'd4), 1, 0, 0);
    cycle(1, l0(8'd2), 1, 0, 0);
    cycle(1, l0(8'd2), 1, 0, 0);
    check("tog2_lane0", out_data[7:0], AVG ? 8'd4 : 8'd8);
    check("tog2_mode", win_mode, AVG);

    // Clear with a pending result and a partial window
    cycle(1, l0(8'd50), 0, 0, 0);
    cycle(1, l0(8'd60), 0, 0, 0);
    cycle(1, l0(8'd70), 0, 1, 0);
    check("clr_valid", out_valid, 1'b0);
    cycle(1, l0(8'd1), 1, 0, 0);
    cycle(1, l0(8'd2), 1, 0, 0);
    cycle(1, l0(8'd3), 1, 0, 0);
    cycle(1, l0(8'd4), 1, 0, 0);
    check("clr_lane0", out_data[7:0], 8'd4);

    // Reset mid-window
    cycle(1, l0(8'd100), 1, 0, 0);
    cycle(1, l0(8'd110), 1, 0, 0);
    reset_mid();
    cycle(1, l0(8'd1), 1, 0, 0);
    cycle(1, l0(8'd2), 1, 0, 0);
    cycle(1, l0(8'd3), 1, 0, 0);
    check("rst_no_result", out_valid, 1'b0);
    cycle(1, l0(8'd5), 1, 0, 0);
    check("rst_lane0", out_data[7:0], 8'd5);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, DWID'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)));
    end
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
